// File: rtl/patch_col_buffer_pkg.sv
// Shared constants and types for the 7-row column assembler.
//
// Contents:
//   PIX_W       pixel width in bits
//   PATCH       column height (rows per emitted column)
//   COL_W       packed column width (PATCH * PIX_W)
//   IDX_W       width of the column/row counters and output indices
//   LB_CNT      number of line buffers (PATCH - 1)
//   CTR_ROW     offset from the newest row to the centre row
//   DEF_WIDTH   default pixels per row
//   DEF_HEIGHT  default rows per frame
//   wrap_inc()  increment that returns to zero after a given last value
package patch_col_buffer_pkg;

    localparam int PIX_W      = 8;
    localparam int PATCH      = 7;
    localparam int COL_W      = PIX_W * PATCH;
    localparam int IDX_W      = 10;
    localparam int LB_CNT     = PATCH - 1;
    localparam int CTR_ROW    = PATCH / 2;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t value, input idx_t last);
        return (value == last) ? '0 : value + idx_t'(1);
    endfunction

endpackage

// File: rtl/patch_col_buffer_lb_ram.sv
// One line buffer: DEPTH x 8-bit storage with a single shared address.
// The read is combinational, so the value seen in a cycle is the content
// before that cycle's write lands (read-before-write at the same address).
//
// Ports:
//   clk   clock, write on rising edge
//   we    write enable
//   addr  read and write address
//   din   write data
//   dout  read data (pre-write content of mem[addr])
module lb_ram
    import patch_col_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          din,
    output pix_t          dout
);

    pix_t mem [DEPTH];

    assign dout = mem[addr];

    // Contents are deliberately not reset; downstream valid masking
    // hides whatever is stored before the first six rows are written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/patch_col_buffer.sv
// Streams raster-order pixels and emits, one cycle later, the vertical
// 7-pixel column ending at the current pixel. Six line buffers form a
// shift chain per column address: each valid pixel moves every buffer's
// entry at that column one row older and stores the new pixel in LB5.
//
// Ports:
//   i_clk          clock, all logic on rising edge
//   i_rst_n        synchronous active-low reset
//   i_valid        i_pixel valid this cycle
//   i_frame_start  with i_valid, marks pixel (row 0, col 0)
//   i_pixel        8-bit grey pixel
//   o_valid        o_col holds a complete 7-row column
//   o_col          {row r, r-1, ..., r-6}; top row in the low byte
//   o_col_idx      column index of o_col
//   o_row_idx      centre row index (r - 3) of o_col
module patch_col_buffer
    import patch_col_buffer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_frame_start,
    input  logic [PIX_W-1:0] i_pixel,
    output logic             o_valid,
    output logic [COL_W-1:0] o_col,
    output logic [IDX_W-1:0] o_col_idx,
    output logic [IDX_W-1:0] o_row_idx
);

    localparam int   LB_AW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam idx_t COL_LAST      = idx_t'(WIDTH - 1);
    localparam idx_t ROW_LAST      = idx_t'(HEIGHT - 1);
    localparam idx_t FIRST_OUT_ROW = idx_t'(PATCH - 1);

    idx_t             col;
    idx_t             row;
    idx_t             cur_col;
    idx_t             cur_row;
    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;
    pix_t             lb_rd [LB_CNT];
    pix_t             lb_wr [LB_CNT];
    logic [COL_W-1:0] col_word;

    // A frame-start pixel is position (0,0) regardless of the counters.
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (i_frame_start) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // The pixel presented during a reset cycle is dropped entirely.
    assign lb_we   = i_valid & i_rst_n;
    assign lb_addr = cur_col[LB_AW-1:0];

    for (genvar k = 0; k < LB_CNT; k++) begin : g_lb
        if (k == LB_CNT - 1) begin : g_newest
            assign lb_wr[k] = i_pixel;
        end else begin : g_shift
            assign lb_wr[k] = lb_rd[k+1];
        end

        lb_ram #(
            .DEPTH (WIDTH),
            .AW    (LB_AW)
        ) u_lb (
            .clk  (i_clk),
            .we   (lb_we),
            .addr (lb_addr),
            .din  (lb_wr[k]),
            .dout (lb_rd[k])
        );
    end

    always_comb begin
        col_word = '0;
        for (int k = 0; k < LB_CNT; k++) begin
            col_word[k*PIX_W +: PIX_W] = lb_rd[k];
        end
        col_word[COL_W-1 -: PIX_W] = i_pixel;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col       <= '0;
            row       <= '0;
            o_valid   <= 1'b0;
            o_col     <= '0;
            o_col_idx <= '0;
            o_row_idx <= '0;
        end else if (i_valid) begin
            col <= wrap_inc(cur_col, COL_LAST);
            if (cur_col == COL_LAST) begin
                row <= wrap_inc(cur_row, ROW_LAST);
            end else begin
                row <= cur_row;
            end
            // Rows 0..5 only prime the buffers; their columns are incomplete.
            o_valid   <= (cur_row >= FIRST_OUT_ROW);
            o_col     <= col_word;
            o_col_idx <= cur_col;
            o_row_idx <= cur_row - idx_t'(CTR_ROW);
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_patch_col_buffer.sv
module tb_patch_col_buffer;

    localparam int W = 16;
    localparam int H = 12;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_frame_start;
    logic [7:0]  i_pixel;
    logic        o_valid;
    logic [55:0] o_col;
    logic [9:0]  o_col_idx;
    logic [9:0]  o_row_idx;

    patch_col_buffer #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_frame_start (i_frame_start),
        .i_pixel       (i_pixel),
        .o_valid       (o_valid),
        .o_col         (o_col),
        .o_col_idx     (o_col_idx),
        .o_row_idx     (o_row_idx)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raster position plus, per column, the last six
    // pixels seen at that column (index 5 = most recent).
    int         m_row = 0;
    int         m_col = 0;
    logic [7:0] hist [W][6];
    logic        exp_valid = 1'b0;
    logic [55:0] exp_col   = '0;
    logic [9:0]  exp_cidx  = '0;
    logic [9:0]  exp_ridx  = '0;

    // Applies one cycle of input, updates the model, samples 1 time unit after the edge.
    task automatic drive(input logic v, input logic fs, input logic [7:0] px);
        int er, ec;
        if (v) begin
            er = fs ? 0 : m_row;
            ec = fs ? 0 : m_col;
            for (int k = 0; k < 6; k++) exp_col[k*8 +: 8] = hist[ec][k];
            exp_col[55:48] = px;
            exp_valid = (er >= 6);
            exp_cidx  = 10'(ec);
            exp_ridx  = 10'(er - 3);
            for (int k = 0; k < 5; k++) hist[ec][k] = hist[ec][k+1];
            hist[ec][5] = px;
            if (ec == W - 1) begin
                m_col = 0;
                m_row = (er == H - 1) ? 0 : er + 1;
            end else begin
                m_col = ec + 1;
                m_row = er;
            end
        end else begin
            exp_valid = 1'b0;
        end
        i_valid       = v;
        i_frame_start = fs;
        i_pixel       = px;
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        exp_valid = 1'b0;
        exp_col = '0;
        exp_cidx = '0;
        exp_ridx = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        tests++; if (o_col !== 56'd0) begin fails++; $display("FAIL reset_col got %h exp 0", o_col); end
        tests++; if (o_col_idx !== 10'd0) begin fails++; $display("FAIL reset_cidx got %0d exp 0", o_col_idx); end
        tests++; if (o_row_idx !== 10'd0) begin fails++; $display("FAIL reset_ridx got %0d exp 0", o_row_idx); end
    endtask

    task automatic test_frame();
        int pulses = 0;
        int first_at = -1;
        int n = 0;
        logic [55:0] first_col = '0;
        logic [9:0]  first_r = '0, last_c = '0, last_r = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0 && c == 0), 8'((r * 7 + c) % 256));
                tests++;
                if (o_valid !== exp_valid) begin fails++; $display("FAIL frame_valid r=%0d c=%0d got %b exp %b", r, c, o_valid, exp_valid); end
                if (exp_valid) begin
                    tests++;
                    if ({o_col, o_col_idx, o_row_idx} !== {exp_col, exp_cidx, exp_ridx}) begin
                        fails++; $display("FAIL frame_data r=%0d c=%0d got %h/%0d/%0d exp %h/%0d/%0d", r, c, o_col, o_col_idx, o_row_idx, exp_col, exp_cidx, exp_ridx);
                    end
                end
                if (o_valid === 1'b1) begin
                    pulses++;
                    if (first_at < 0) begin first_at = n; first_col = o_col; first_r = o_row_idx; end
                    last_c = o_col_idx;
                    last_r = o_row_idx;
                end
                n++;
            end
        end
        tests++; if (first_at != 96) begin fails++; $display("FAIL frame_first_at got %0d exp 96", first_at); end
        tests++; if (first_col !== 56'h2A231C150E0700) begin fails++; $display("FAIL frame_first_col got %h exp 2a231c150e0700", first_col); end
        tests++; if (first_r !== 10'd3) begin fails++; $display("FAIL frame_first_ridx got %0d exp 3", first_r); end
        tests++; if (pulses != 96) begin fails++; $display("FAIL frame_pulses got %0d exp 96", pulses); end
        tests++; if (last_c !== 10'd15 || last_r !== 10'd8) begin fails++; $display("FAIL frame_last got c=%0d r=%0d exp c=15 r=8", last_c, last_r); end
    endtask

    task automatic test_second_frame();
        int pulses = 0;
        int early = 0;
        for (int n = 0; n < W * H; n++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            tests++;
            if (o_valid !== exp_valid) begin fails++; $display("FAIL frame2_valid n=%0d got %b exp %b", n, o_valid, exp_valid); end
            if (exp_valid) begin
                tests++;
                if ({o_col, o_col_idx, o_row_idx} !== {exp_col, exp_cidx, exp_ridx}) begin
                    fails++; $display("FAIL frame2_data n=%0d got %h/%0d/%0d exp %h/%0d/%0d", n, o_col, o_col_idx, o_row_idx, exp_col, exp_cidx, exp_ridx);
                end
            end
            if (o_valid === 1'b1) begin pulses++; if (n < 96) early++; end
        end
        tests++; if (pulses != 96 || early != 0) begin fails++; $display("FAIL frame2_pulses got %0d early %0d exp 96 early 0", pulses, early); end
    endtask

    task automatic test_gaps();
        logic [55:0] held;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0 && c == 0), 8'($urandom));
                tests++;
                if (o_valid !== exp_valid) begin fails++; $display("FAIL gap_valid r=%0d c=%0d got %b exp %b", r, c, o_valid, exp_valid); end
                if (exp_valid) begin
                    tests++;
                    if ({o_col, o_col_idx, o_row_idx} !== {exp_col, exp_cidx, exp_ridx}) begin
                        fails++; $display("FAIL gap_data r=%0d c=%0d got %h/%0d/%0d exp %h/%0d/%0d", r, c, o_col, o_col_idx, o_row_idx, exp_col, exp_cidx, exp_ridx);
                    end
                end
                if (r == 8) begin
                    tests++;
                    if (o_col_idx !== 10'(c) || o_row_idx !== 10'd5) begin fails++; $display("FAIL gap_seq got c=%0d r=%0d exp c=%0d r=5", o_col_idx, o_row_idx, c); end
                    held = o_col;
                    drive(1'b0, 1'b0, 8'($urandom));
                    tests++;
                    if (o_valid !== 1'b0 || o_col !== held || o_col_idx !== 10'(c)) begin
                        fails++; $display("FAIL gap_hold c=%0d got v=%b col=%h idx=%0d exp v=0 col=%h idx=%0d", c, o_valid, o_col, o_col_idx, held, c);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_start_mid();
        int early = 0;
        logic newok;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 9 && c == 5) break;
                drive(1'b1, (r == 0 && c == 0), {1'b0, 7'($urandom)});
            end
            if (r == 9) break;
        end
        for (int n = 0; n < 96; n++) begin
            drive(1'b1, (n == 0), {1'b1, 7'($urandom)});
            if (o_valid !== 1'b0) early++;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL fs_mid_early got %0d pulses exp 0", early); end
        drive(1'b1, 1'b0, {1'b1, 7'($urandom)});
        newok = 1'b1;
        for (int k = 0; k < 7; k++) if (o_col[k*8+7] !== 1'b1) newok = 1'b0;
        tests++;
        if (o_valid !== 1'b1 || o_col_idx !== 10'd0 || o_row_idx !== 10'd3 || !newok) begin
            fails++; $display("FAIL fs_mid_first got v=%b c=%0d r=%0d col=%h exp v=1 c=0 r=3 new data", o_valid, o_col_idx, o_row_idx, o_col);
        end
        tests++; if (o_col !== exp_col) begin fails++; $display("FAIL fs_mid_col got %h exp %h", o_col, exp_col); end
        for (int n = 0; n < 2 * W; n++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            tests++;
            if (o_valid !== exp_valid || (exp_valid && {o_col, o_col_idx, o_row_idx} !== {exp_col, exp_cidx, exp_ridx})) begin
                fails++; $display("FAIL fs_mid_tail n=%0d got %b/%h exp %b/%h", n, o_valid, o_col, exp_valid, exp_col);
            end
        end
    endtask

    task automatic test_reset_mid();
        int early = 0;
        drive(1'b1, 1'b1, 8'($urandom));
        while (!(m_row == 7 && m_col == 3)) drive(1'b1, 1'b0, 8'($urandom));
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b exp 1", o_valid); end
        apply_reset();
        tests++;
        if ({o_valid, o_col, o_col_idx, o_row_idx} !== 77'd0) begin
            fails++; $display("FAIL rst_mid_zero got v=%b col=%h c=%0d r=%0d exp all 0", o_valid, o_col, o_col_idx, o_row_idx);
        end
        for (int n = 0; n < 96; n++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            if (o_valid !== 1'b0) early++;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL rst_mid_early got %0d pulses exp 0", early); end
        drive(1'b1, 1'b0, 8'($urandom));
        tests++;
        if (o_valid !== 1'b1 || o_col_idx !== 10'd0 || o_row_idx !== 10'd3 || o_col !== exp_col) begin
            fails++; $display("FAIL rst_mid_resume got v=%b c=%0d r=%0d col=%h exp v=1 c=0 r=3 col=%h", o_valid, o_col_idx, o_row_idx, o_col, exp_col);
        end
    endtask

    task automatic test_back_to_back();
        logic v, fs;
        for (int n = 0; n < 1500; n++) begin
            v  = ($urandom_range(0, 99) < 80);
            fs = ($urandom_range(0, 299) == 0);
            drive(v, fs, 8'($urandom));
            tests++;
            if (o_valid !== exp_valid || o_col_idx !== exp_cidx || o_row_idx !== exp_ridx) begin
                fails++; $display("FAIL rand_ctl n=%0d got %b/%0d/%0d exp %b/%0d/%0d", n, o_valid, o_col_idx, o_row_idx, exp_valid, exp_cidx, exp_ridx);
            end
            if (exp_valid) begin
                tests++;
                if (o_col !== exp_col) begin fails++; $display("FAIL rand_col n=%0d got %h exp %h", n, o_col, exp_col); end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < W; c++) for (int k = 0; k < 6; k++) hist[c][k] = 8'd0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        i_pixel = 8'd0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_frame();
        test_second_frame();
        test_gaps();
        test_frame_start_mid();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/patch_col_buffer.md
PATCH_COL_BUFFER -- requirements
Module: patch_col_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per image row.
REQ-002 SHALL have parameter HEIGHT, default 480, rows per frame.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  i_pixel valid this cycle (raster order).
REQ-006 SHALL have port i_frame_start  input  1  qualified by i_valid; marks pixel (row 0, col 0).
REQ-007 SHALL have port i_pixel  input  8  unsigned grey pixel.
REQ-008 SHALL have port o_valid  output  1  o_col holds a complete 7-row column.
REQ-009 SHALL have port o_col  output  56  7 pixels; o_col[7:0] = top (row r-6) ... o_col[55:48] = bottom (row r).
REQ-010 SHALL have port o_col_idx  output  10  column index c of o_col.
REQ-011 SHALL have port o_row_idx  output  10  centre row index r-3 of o_col.

Function
REQ-012 SHALL hold 6 line buffers LB0..LB5, each WIDTH x 8 bits; LB0 oldest row, LB5 newest completed row.
REQ-013 SHALL keep a column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), advancing only when i_valid=1.
REQ-014 On i_valid: col increments; at col=WIDTH-1, col wraps to 0 and row increments; at row=HEIGHT-1 with col=WIDTH-1, row wraps to 0.
REQ-015 On i_valid with i_frame_start=1: current pixel SHALL be treated as (0,0); next pixel is (0,1); overrides any counter state.
REQ-016 On i_valid, at address col: LBk[col] <= LBk+1[col] for k=0..4, LB5[col] <= i_pixel (read-before-write).
REQ-017 On i_valid, o_col SHALL register {i_pixel, LB5[col], LB4[col], ..., LB0[col]} (pre-write values); latency exactly 1 cycle.
REQ-018 o_valid SHALL be 1 in the cycle after an i_valid pixel with row >= 6, else 0.
REQ-019 o_valid SHALL be 0 in the cycle after any cycle with i_valid=0; o_col, o_col_idx, o_row_idx hold their last values.
REQ-020 o_col_idx SHALL equal the pixel's col; o_row_idx SHALL equal its row - 3.
REQ-021 Rows 0..5 of each frame SHALL update buffers but never assert o_valid, including after mid-frame i_frame_start.
REQ-022 Back-to-back i_valid SHALL sustain one column per cycle without stall; no backpressure input exists.
REQ-023 i_frame_start with i_valid=0 SHALL be ignored.

Reset
REQ-024 With i_rst_n=0 at a clock edge: col=0, row=0, o_valid=0, o_col=0, o_col_idx=0, o_row_idx=0.
REQ-025 Line buffer contents SHALL NOT be reset; stale data is masked by REQ-018.
REQ-026 After mid-frame reset, the next i_valid pixel SHALL be treated as (0,0) with or without i_frame_start.

Structure
REQ-027 Shared package SHALL define PIX_W=8, PATCH=7, COL_W=56, IDX_W=10, and default WIDTH/HEIGHT constants.
REQ-028 One sub-module lb_ram (WIDTH x 8, one address, read-before-write, synchronous write) SHALL be instantiated 6 times.
REQ-029 Counter, valid and index logic SHALL reside in patch_col_buffer; no multipliers or dividers.

Verification
REQ-030 Reset, then frame with pixel = (row*7+col) mod 256, WIDTH=16, HEIGHT=12 -> o_valid first high after pixel (6,0); o_col bytes = values of rows 0..6 col 0, o_row_idx=3.
REQ-031 Same frame -> exactly (12-6)*16 = 96 o_valid pulses; last o_col_idx=15, o_row_idx=8.
REQ-032 i_valid toggled 1,0,1,0 during row 8 -> o_valid mirrors i_valid delayed by 1; o_col unchanged across gaps; no skipped or repeated columns.
REQ-033 i_frame_start asserted at (9,5) -> o_valid 0 for next 6*16 pixels; first valid o_col at new row 6 col 0 contains only new-frame data.
REQ-034 i_rst_n low one cycle at (7,3), then stream resumes -> all outputs 0 after reset edge; o_valid stays 0 until 96 further pixels.
REQ-035 Second frame immediately after first (row wrap 11->0, no frame_start) -> o_valid suppressed for rows 0..5, then correct columns resume at row 6.
